// File: rtl/types_pkg.sv
// Shared register-file bus types plus the writeback queue entry record.
package types_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;

  typedef logic [ADDRESS_WIDTH-1:0] ADDR_BUS;
  typedef logic [DATA_WIDTH-1:0]    DATA_BUS;

  // One pending register write: destination register and value.
  typedef struct packed {
    ADDR_BUS addr;
    DATA_BUS data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending writes held in the writeback queue.
// Entries are walked oldest (head) to youngest; a later match overrides an
// earlier one, so the value returned is the one decode must observe.
module wb_fwd_match
  import types_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PTR_W-1:0]      head_i,
  input  ADDR_BUS               addr_i,
  output logic                  hit_o,
  output DATA_BUS               data_o
);

  logic [PTR_W-1:0] idx;

  // Age-ordered scan; register x0 is hard-wired and can never be forwarded.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] && (entries_i[idx].addr == addr_i) && (addr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers up to DEPTH register writes between result
// producers and the register-file write port, drains one per granted cycle
// in acceptance order, and forwards the youngest pending value to decode.
//
// Handshake: a write transfers on a cycle where in_valid && in_ready at the
// rising edge. in_ready depends only on occupancy (never on in_valid), and a
// full queue refuses input even if it pops in the same cycle. Writes to x0
// complete the handshake but are dropped.
module wb_queue
  import types_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  ADDR_BUS          in_addr,
  input  DATA_BUS          in_data,
  input  logic             drain_en,
  output logic             we_out,
  output ADDR_BUS          ad_out,
  output DATA_BUS          wd_out,
  input  ADDR_BUS          rs1_addr,
  input  ADDR_BUS          rs2_addr,
  output logic             rs1_hit,
  output logic             rs2_hit,
  output DATA_BUS          rs1_data,
  output DATA_BUS          rs2_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      valid_mask;
  logic                  push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign in_ready = !full;

  // A write port grant during reset is not honoured: pending writes are
  // discarded as a whole rather than partially drained.
  assign we_out = !empty && drain_en && !rst;
  assign ad_out = empty ? '0 : mem_q[head_q].addr;
  assign wd_out = empty ? '0 : mem_q[head_q].data;

  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop  = we_out;

  // Next-state for pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful where valid_mask is set.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[tail_q] <= '{addr: in_addr, data: in_data};
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_mask[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs1 (
    .entries_i (mem_q),
    .valid_i   (valid_mask),
    .head_i    (head_q),
    .addr_i    (rs1_addr),
    .hit_o     (rs1_hit),
    .data_o    (rs1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs2 (
    .entries_i (mem_q),
    .valid_i   (valid_mask),
    .head_i    (head_q),
    .addr_i    (rs2_addr),
    .hit_o     (rs2_hit),
    .data_o    (rs2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: table of per-cycle vectors (inputs plus expected
// outputs observed before the edge), then a wrap-around sequence scored
// against an expected queue.
module tb_wb_queue;
  import types_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int W     = ADDRESS_WIDTH + DATA_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  ADDR_BUS          in_addr;
  DATA_BUS          in_data;
  logic             drain_en;
  logic             we_out;
  ADDR_BUS          ad_out;
  DATA_BUS          wd_out;
  ADDR_BUS          rs1_addr, rs2_addr;
  logic             rs1_hit, rs2_hit;
  DATA_BUS          rs1_data, rs2_data;
  logic [CNT_W-1:0] count;
  logic             empty, full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .we_out   (we_out),
    .ad_out   (ad_out),
    .wd_out   (wd_out),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  typedef struct {
    logic    rst;
    logic    iv;
    ADDR_BUS ia;
    DATA_BUS id;
    logic    de;
    ADDR_BUS r1;
    ADDR_BUS r2;
    logic    ir;
    logic    we;
    ADDR_BUS ad;
    DATA_BUS wd;
    logic    h1;
    DATA_BUS d1;
    logic    h2;
    DATA_BUS d2;
    int      cnt;
    logic    emp;
    logic    ful;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, int ia, logic [31:0] id, logic de,
                              int r1, int r2, logic ir, logic we, int ad,
                              logic [31:0] wd, logic h1, logic [31:0] d1,
                              logic h2, logic [31:0] d2, int cnt, logic emp, logic ful);
    vec_t v;
    v.rst = r;  v.iv = iv; v.ia = ADDR_BUS'(ia); v.id = id; v.de = de;
    v.r1 = ADDR_BUS'(r1); v.r2 = ADDR_BUS'(r2);
    v.ir = ir; v.we = we; v.ad = ADDR_BUS'(ad); v.wd = wd;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    v.cnt = cnt; v.emp = emp; v.ful = ful;
    return v;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic iv, input ADDR_BUS ia, input DATA_BUS id,
                       input logic de, input ADDR_BUS r1, input ADDR_BUS r2);
    rst = r; in_valid = iv; in_addr = ia; in_data = id;
    drain_en = de; rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("in_ready", i, 64'(in_ready), 64'(v.ir));
    chk("we_out",   i, 64'(we_out),   64'(v.we));
    chk("ad_out",   i, 64'(ad_out),   64'(v.ad));
    chk("wd_out",   i, 64'(wd_out),   64'(v.wd));
    chk("rs1_hit",  i, 64'(rs1_hit),  64'(v.h1));
    chk("rs1_data", i, 64'(rs1_data), 64'(v.d1));
    chk("rs2_hit",  i, 64'(rs2_hit),  64'(v.h2));
    chk("rs2_data", i, 64'(rs2_data), 64'(v.d2));
    chk("count",    i, 64'(count),    64'(v.cnt));
    chk("empty",    i, 64'(empty),    64'(v.emp));
    chk("full",     i, 64'(full),     64'(v.ful));
  endtask

  initial begin
    //            rst iv ia  id            de r1 r2  ir we ad wd            h1 d1            h2 d2   cnt emp ful
    // reset state
    vecs.push_back(mk(0, 0, 0,  0,            0, 5, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    // single entry: push, forward, drain
    vecs.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 5, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 5, 0,  1, 0, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 5, 0,  1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 5, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    // fill to full, fifth push held, drain in order
    vecs.push_back(mk(0, 1, 1,  32'h11,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 1, 2,  32'h22,       0, 0, 0,  1, 0, 1, 32'h11,       0, 0,            0, 0,   1, 0, 0));
    vecs.push_back(mk(0, 1, 3,  32'h33,       0, 0, 0,  1, 0, 1, 32'h11,       0, 0,            0, 0,   2, 0, 0));
    vecs.push_back(mk(0, 1, 4,  32'h44,       0, 0, 0,  1, 0, 1, 32'h11,       0, 0,            0, 0,   3, 0, 0));
    vecs.push_back(mk(0, 1, 5,  32'h55,       0, 4, 1,  0, 0, 1, 32'h11,       1, 32'h44,       1, 32'h11, 4, 0, 1));
    vecs.push_back(mk(0, 1, 5,  32'h55,       1, 4, 0,  0, 1, 1, 32'h11,       1, 32'h44,       0, 0,   4, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0,            1, 0, 0,  1, 1, 2, 32'h22,       0, 0,            0, 0,   3, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 0, 0,  1, 1, 3, 32'h33,       0, 0,            0, 0,   2, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 5, 0,  1, 1, 4, 32'h44,       0, 0,            0, 0,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    // repeated writes to x7: youngest wins
    vecs.push_back(mk(0, 1, 7,  32'h1,        0, 0, 7,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 1, 7,  32'h2,        0, 0, 7,  1, 0, 7, 32'h1,        0, 0,            1, 32'h1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0, 7,  1, 0, 7, 32'h1,        0, 0,            1, 32'h2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 0, 7,  1, 1, 7, 32'h1,        0, 0,            1, 32'h2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 0, 7,  1, 1, 7, 32'h2,        0, 0,            1, 32'h2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0, 7,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    // x0 writes are accepted but dropped
    vecs.push_back(mk(0, 1, 0,  32'hFFFF,     0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    // reset with three pending entries and the write port granted
    vecs.push_back(mk(0, 1, 9,  32'h9,        0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));
    vecs.push_back(mk(0, 1, 10, 32'hA,        0, 0, 0,  1, 0, 9, 32'h9,        0, 0,            0, 0,   1, 0, 0));
    vecs.push_back(mk(0, 1, 11, 32'hB,        0, 11, 0, 1, 0, 9, 32'h9,        0, 0,            0, 0,   2, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0,            1, 11, 0, 1, 0, 9, 32'h9,        1, 32'hB,        0, 0,   3, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 11, 0, 1, 0, 0, 0,            0, 0,            0, 0,   0, 1, 0));

    drive(1, 0, '0, '0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, '0, '0, 0, '0, '0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].id, vecs[i].de, vecs[i].r1, vecs[i].r2);
      #1;
      check_vec(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Wrap sequence: hold two entries, then push and pop together for ten
    // cycles so head and tail both cross DEPTH-1 -> 0 several times.
    drive(0, 0, '0, '0, 0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, ADDR_BUS'(k + 1), DATA_BUS'(32'hA000 + k), 0, '0, '0);
      exp_q.push_back({ADDR_BUS'(k + 1), DATA_BUS'(32'hA000 + k)});
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 10; k++) begin
      logic [W-1:0] e;
      ADDR_BUS a;
      a = ADDR_BUS'(3 + k);
      drive(0, 1, a, DATA_BUS'(32'hB000 + k), 1, a, '0);
      #1;
      chk("wrap_count", k, 64'(count), 64'(2));
      chk("wrap_we",    k, 64'(we_out), 64'(1));
      chk("wrap_rdy",   k, 64'(in_ready), 64'(1));
      chk("wrap_rs1_miss", k, 64'(rs1_hit), 64'(0));
      e = exp_q.pop_front();
      chk("wrap_entry", k, 64'({ad_out, wd_out}), 64'(e));
      exp_q.push_back({a, DATA_BUS'(32'hB000 + k)});
      @(posedge clk);
      #1;
    end
    drive(0, 0, '0, '0, 1, '0, '0);
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] e;
      #1;
      chk("tail_we", k, 64'(we_out), 64'(1));
      e = exp_q.pop_front();
      chk("tail_entry", k, 64'({ad_out, wd_out}), 64'(e));
      @(posedge clk);
      #1;
    end
    chk("final_empty", 0, 64'(empty), 64'(1));
    chk("final_count", 0, 64'(count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
